// File: rtl/wb_port_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : wb_port_scheduler                                               |
// | Brief  : Arbitrates load-return, ALU and JAL onto one register-file     |
// |          write port, with a 2-entry ALU/JAL holding FIFO.                |
// |          Optional sticky err output under macro WB_SCHED_ERR_EN.         |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module wb_port_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_vld,
    input  logic [3:0]  alu_dst,
    input  logic [15:0] alu_data,
    input  logic        jal_vld,
    input  logic [15:0] link_data,
    input  logic        ld_req,
    input  logic [3:0]  ld_dst,
    input  logic        mem_vld,
    input  logic [15:0] mem_data,
    output logic        wb_en,
    output logic [3:0]  wb_dst,
    output logic [15:0] wb_data,
    output logic        stall,
    output logic        ld_pend
`ifdef WB_SCHED_ERR_EN
    ,
    output logic        err
`endif
);

    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_ld_wait = 1'b1;
    localparam logic [3:0] c_link_reg   = 4'hF;

    logic [0:0]  r_state;
    logic [3:0]  r_pend_dst;
    logic [3:0]  r_fifo_dst  [2];
    logic [15:0] r_fifo_data [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_cnt;
    logic        r_wb_en;
    logic [3:0]  r_wb_dst;
    logic [15:0] r_wb_data;

    logic        w_ld_wait;
    logic        w_ld_ret;
    logic        w_stall;
    logic        w_ld_acc;
    logic        w_new_vld;
    logic [3:0]  w_new_dst;
    logic [15:0] w_new_data;
    logic        w_fifo_ne;
    logic        w_fifo_full;
    logic        w_deq;
    logic        w_enq_req;
    logic        w_drop;
    logic        w_enq;
    logic        w_win;
    logic [3:0]  w_win_dst;
    logic [15:0] w_win_data;

    assign w_ld_wait   = (r_state == c_st_ld_wait);
    assign w_ld_ret    = w_ld_wait & mem_vld;
    assign w_fifo_ne   = (r_cnt != 2'd0);
    assign w_fifo_full = (r_cnt == 2'd2);
    assign w_stall     = w_fifo_full | (w_ld_wait & ld_req & ~mem_vld);
    assign w_ld_acc    = ld_req & ~w_stall;

    // JAL shadows a simultaneous ALU result entirely.
    assign w_new_vld  = jal_vld | alu_vld;
    assign w_new_dst  = jal_vld ? c_link_reg : alu_dst;
    assign w_new_data = jal_vld ? link_data : alu_data;

    // Queue behind older entries or behind a winning load so ALU/JAL order holds.
    assign w_deq     = w_fifo_ne & ~w_ld_ret;
    assign w_enq_req = w_new_vld & (w_fifo_ne | w_ld_ret);
    assign w_drop    = w_enq_req & w_fifo_full & ~w_deq;
    assign w_enq     = w_enq_req & ~w_drop;

    always_comb begin
        w_win      = 1'b0;
        w_win_dst  = 4'd0;
        w_win_data = 16'd0;
        if (w_ld_ret) begin
            w_win      = 1'b1;
            w_win_dst  = r_pend_dst;
            w_win_data = mem_data;
        end else if (w_fifo_ne) begin
            w_win      = 1'b1;
            w_win_dst  = r_fifo_dst[r_rd_ptr];
            w_win_data = r_fifo_data[r_rd_ptr];
        end else if (w_new_vld) begin
            w_win      = 1'b1;
            w_win_dst  = w_new_dst;
            w_win_data = w_new_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_pend_dst <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_ld_acc) begin
                        r_state    <= c_st_ld_wait;
                        r_pend_dst <= ld_dst;
                    end
                end
                c_st_ld_wait: begin
                    if (mem_vld) begin
                        if (w_ld_acc) begin
                            r_pend_dst <= ld_dst;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_cnt          <= 2'd0;
            r_fifo_dst[0]  <= 4'd0;
            r_fifo_dst[1]  <= 4'd0;
            r_fifo_data[0] <= 16'd0;
            r_fifo_data[1] <= 16'd0;
        end else begin
            if (w_enq) begin
                r_fifo_dst[r_wr_ptr]  <= w_new_dst;
                r_fifo_data[r_wr_ptr] <= w_new_data;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_enq, w_deq})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Address and data hold on idle cycles; only the enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_en   <= 1'b0;
            r_wb_dst  <= 4'd0;
            r_wb_data <= 16'd0;
        end else begin
            r_wb_en <= w_win;
            if (w_win) begin
                r_wb_dst  <= w_win_dst;
                r_wb_data <= w_win_data;
            end
        end
    end

    assign wb_en   = r_wb_en;
    assign wb_dst  = r_wb_dst;
    assign wb_data = r_wb_data;
    assign stall   = w_stall;
    assign ld_pend = w_ld_wait;

`ifdef WB_SCHED_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_drop | (~w_ld_wait & mem_vld) | (jal_vld & alu_vld)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: doc/wb_port_scheduler.md
WB_PORT_SCHEDULER -- requirements
Module: wb_port_scheduler

Interface
REQ-001 The module SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 The module SHALL have these ports (name direction width meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_vld  in  1  ALU result ready for writeback
- alu_dst  in  4  ALU destination register
- alu_data  in  16  ALU result
- jal_vld  in  1  jump-and-link writeback request; destination is fixed at 4'hF
- link_data  in  16  link value
- ld_req  in  1  load issued
- ld_dst  in  4  load destination
- mem_vld  in  1  load data returned
- mem_data  in  16  load data
- wb_en  out  1  register-file write enable
- wb_dst  out  4  write address
- wb_data  out  16  write data
- stall  out  1  upstream hold
- ld_pend  out  1  load outstanding

Function
REQ-003 The module SHALL share the single register-file write port between the load-return, ALU and JAL sources.
REQ-004 wb_en, wb_dst and wb_data SHALL be registered, with a latency of one cycle from the accepted source to the write.
REQ-005 The FSM SHALL have two states, IDLE and LD_WAIT; ld_pend SHALL be 1 exactly in LD_WAIT.
REQ-006 FSM transitions SHALL be:
- IDLE with ld_req: go to LD_WAIT and capture ld_dst in pend_dst.
- LD_WAIT with mem_vld and no ld_req: go to IDLE.
- LD_WAIT with mem_vld and ld_req: stay in LD_WAIT and capture the new ld_dst.
REQ-007 mem_vld in IDLE SHALL be ignored; no write occurs.
REQ-008 A new request SHALL be JAL if jal_vld is 1; otherwise it SHALL be ALU if alu_vld is 1.
REQ-009 When jal_vld and alu_vld are both 1, JAL SHALL win and the ALU request SHALL be discarded.
REQ-010 Each cycle, the write winner SHALL be chosen in this priority order: load return (LD_WAIT and mem_vld), then the FIFO head, then the new request.
REQ-011 A 2-entry FIFO ({dst, data}) SHALL hold ALU/JAL requests that cannot be written.
- A new request SHALL be enqueued when the FIFO is non-empty, or when a load return wins, so that ALU/JAL order is preserved.
REQ-012 The FIFO SHALL dequeue its head when the head wins.
- Enqueue and dequeue in the same cycle SHALL be permitted; the count is then unchanged.
REQ-013 Count SHALL be 0..2 and pointers SHALL wrap modulo 2.
REQ-014 An enqueue at count==2 without a dequeue SHALL drop the request; FIFO contents SHALL be unchanged.
REQ-015 stall SHALL be combinational: (count==2) OR (LD_WAIT AND ld_req AND NOT mem_vld).
- ld_req while stall is 1 SHALL be ignored.
REQ-016 A cycle with no winner SHALL produce wb_en=0 on the next cycle; wb_dst and wb_data SHALL hold their values.

Reset
REQ-017 Asserting rst_n=0 SHALL force the following immediately, including mid-load or with the FIFO non-empty:
- state IDLE
- FIFO count 0 and pointers 0
- pend_dst 0
- wb_en 0, wb_dst 0, wb_data 0
- ld_pend 0
REQ-018 stall SHALL read 0 during reset.
REQ-019 A mem_vld arriving after reset for a pre-reset load SHALL be ignored, as it falls under REQ-007.

Configuration
REQ-020 With macro WB_SCHED_ERR_EN defined, the module SHALL add output err (1 bit), reset to 0.
- err SHALL be set sticky on a FIFO drop (REQ-014), on mem_vld in IDLE, or on a simultaneous jal_vld and alu_vld.
- err SHALL be cleared only by reset.
REQ-021 Without WB_SCHED_ERR_EN, the err port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-022 Direct ALU: alu_vld=1, dst=3, data=16'h1234, FIFO empty, IDLE -> next cycle wb_en=1, wb_dst=3, wb_data=16'h1234.
REQ-023 Load collision:
- ld_req with ld_dst=5.
- Two cycles later, mem_vld=1 with mem_data=16'hBEEF, and alu_vld=1 with dst=2, data=16'h0042 in the same cycle.
- Required: writes of (5, BEEF) and then (2, 0042) on consecutive cycles; ld_pend drops after the return.
REQ-024 FIFO fill:
- Hold LD_WAIT; pulse alu_vld on two cycles that each coincide with a mem_vld return.
- Required: stall=1 at count==2; a third alu_vld is dropped (err=1 with WB_SCHED_ERR_EN); the queued entries then drain in order.
REQ-025 JAL priority: jal_vld=1 with link_data=16'h00A0, and alu_vld=1 in the same cycle -> single write (15, 00A0); the ALU result is never written.
REQ-026 Back-to-back loads: in LD_WAIT, mem_vld and ld_req (ld_dst=7) in the same cycle -> stall=0, state stays LD_WAIT, and the next return writes dst 7.
REQ-027 Reset mid-operation: assert rst_n=0 with count==2 in LD_WAIT -> all outputs 0 immediately; after release, mem_vld=1 produces no write.
